// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg: shared frame sizing, R/W encoding and FSM states for the SPI register file
package spi_regfile_pkg;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ = 1'b0;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  function automatic int frame_bits(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction
endpackage

// File: rtl/spi_regfile_peripheral_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with edge detection on the synchronised level
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input logic clk,
  input logic rst,
  input logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end
  assign level = sync[STAGES-1];
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral: SPI mode-0 register file with read-back, write strobe and frame-error pulse
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  input logic sclk,
  input logic copi,
  input logic ncs,
  output logic cipo,
  output logic cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic frame_err
);
  localparam int FB = frame_bits(ADDR_W, DATA_W);
  localparam int CMD_BITS = 1 + ADDR_W;
  localparam int CW = $clog2(FB + 2);
  localparam logic [ADDR_W:0] NR = (ADDR_W + 1)'(NUM_REGS);
  logic sclk_l, sclk_r, sclk_f, copi_l, copi_r, copi_f, ncs_l, ncs_r, ncs_f;
  logic unused_edges;
  state_t state, state_nx;
  logic [CW-1:0] bit_cnt;
  logic [FB-1:0] rx_shift;
  logic [CMD_BITS-1:0] cmd_w;
  logic rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] tx_shift, rd_val;
  logic start, commit, samp, cmd_last, data_last, tx_adv, len_ok, addr_ok, do_wr, do_err;
  logic pend_wr, pend_err;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk), .level(sclk_l), .rise(sclk_r), .fall(sclk_f)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst(rst), .d(copi), .level(copi_l), .rise(copi_r), .fall(copi_f)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst(rst), .d(ncs), .level(ncs_l), .rise(ncs_r), .fall(ncs_f)
  );
  assign unused_edges = ^{sclk_l, copi_r, copi_f};
  assign cipo_oe = ~ncs_l;
  assign cipo = tx_shift[DATA_W-1];
  assign cmd_w = {rx_shift[ADDR_W-1:0], copi_l};
  // chip-select edges take priority over any sclk edge detected in the same clk
  always_comb begin
    start = (state == IDLE) && ncs_f;
    commit = (state != IDLE) && ncs_r;
    samp = sclk_r && !ncs_r && (state != IDLE);
    cmd_last = samp && (state == CMD) && (bit_cnt == CW'(CMD_BITS - 1));
    data_last = samp && (state == DATA) && (bit_cnt == CW'(FB - 1));
    tx_adv = sclk_f && (state == DATA) && (bit_cnt > CW'(CMD_BITS));
    len_ok = bit_cnt == CW'(FB);
    addr_ok = {1'b0, addr} < NR;
    do_wr = commit && len_ok && (rw == RW_WRITE) && addr_ok;
    do_err = commit && (!len_ok || ((rw == RW_WRITE) && !addr_ok));
    state_nx = (state == IDLE) ? (ncs_f ? CMD : IDLE) :
               ncs_r ? IDLE : cmd_last ? DATA : data_last ? DONE : state;
  end
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++)
      rd_val = (cmd_w[ADDR_W-1:0] == ADDR_W'(k)) ? regs_out[k*DATA_W +: DATA_W] : rd_val;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      rx_shift <= '0;
      rw <= RW_READ;
      addr <= '0;
      tx_shift <= '0;
      pend_wr <= 1'b0;
      pend_err <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      if (start) begin
        bit_cnt <= '0;
        rx_shift <= '0;
      end else if (samp) begin
        bit_cnt <= (bit_cnt == CW'(FB + 1)) ? bit_cnt : bit_cnt + 1'b1;
        rx_shift <= {rx_shift[FB-2:0], copi_l};
      end
      if (cmd_last) begin
        rw <= cmd_w[ADDR_W];
        addr <= cmd_w[ADDR_W-1:0];
      end
      tx_shift <= (start || commit) ? '0 :
                  cmd_last ? ((cmd_w[ADDR_W] == RW_READ) ? rd_val : '0) :
                  tx_adv ? (tx_shift << 1) : tx_shift;
      pend_wr <= do_wr;
      pend_err <= do_err;
      pend_addr <= do_wr ? addr : pend_addr;
      pend_data <= do_wr ? rx_shift[DATA_W-1:0] : pend_data;
    end
  end
  // the register bank only ever changes here, one clk after the commit decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_out <= '0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= pend_wr;
      frame_err <= pend_err;
      wr_addr <= pend_wr ? pend_addr : wr_addr;
      for (int k = 0; k < NUM_REGS; k++)
        if (pend_wr && (pend_addr == ADDR_W'(k))) regs_out[k*DATA_W +: DATA_W] <= pend_data;
    end
  end
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb_spi_regfile_peripheral: scoreboard bench for the default and a wide/deep configuration
module tb_spi_regfile_peripheral;
  localparam int AW = 7, DW = 8, NR = 5;
  localparam int AW2 = 4, DW2 = 16, NR2 = 16;
  typedef struct {int addr; logic [31:0] data;} wr_t;
  logic clk = 0, rst = 1, sclk = 0, copi = 0, ncs_a = 1, ncs_b = 1;
  logic cipo_a, oe_a, ws_a, fe_a, cipo_b, oe_b, ws_b, fe_b;
  logic [NR*DW-1:0] regs_a, model_a;
  logic [NR2*DW2-1:0] regs_b, model_b;
  logic [AW-1:0] wa_a;
  logic [AW2-1:0] wa_b;
  int passed = 0, total = 0;
  int ws_cnt_a = 0, fe_cnt_a = 0, ws_cnt_b = 0, fe_cnt_b = 0;
  wr_t wq_a[$], wq_b[$], ea, eb;
  logic [31:0] rd_q[$];
  logic [31:0] rx, rexp;
  logic oe_mid;
  bit done = 0;

  spi_regfile_peripheral #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs_a), .cipo(cipo_a), .cipo_oe(oe_a),
    .regs_out(regs_a), .wr_strobe(ws_a), .wr_addr(wa_a), .frame_err(fe_a));
  spi_regfile_peripheral #(.NUM_REGS(NR2), .ADDR_W(AW2), .DATA_W(DW2), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs_b), .cipo(cipo_b), .cipo_oe(oe_b),
    .regs_out(regs_b), .wr_strobe(ws_b), .wr_addr(wa_b), .frame_err(fe_b));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fe_a) fe_cnt_a++;
    if (fe_b) fe_cnt_b++;
    if (ws_a) begin
      ws_cnt_a++;
      total++;
      if (wq_a.size() == 0) $display("FAIL wr_a unexpected strobe addr=%0d", wa_a);
      else begin
        ea = wq_a.pop_front();
        if (wa_a !== ea.addr[AW-1:0] || regs_a[ea.addr*DW +: DW] !== ea.data[DW-1:0])
          $display("FAIL wr_a got addr=%0d data=%h want addr=%0d data=%h",
                   wa_a, regs_a[ea.addr*DW +: DW], ea.addr, ea.data[DW-1:0]);
        else passed++;
      end
    end
    if (ws_b) begin
      ws_cnt_b++;
      total++;
      if (wq_b.size() == 0) $display("FAIL wr_b unexpected strobe addr=%0d", wa_b);
      else begin
        eb = wq_b.pop_front();
        if (wa_b !== eb.addr[AW2-1:0] || regs_b[eb.addr*DW2 +: DW2] !== eb.data[DW2-1:0])
          $display("FAIL wr_b got addr=%0d data=%h want addr=%0d data=%h",
                   wa_b, regs_b[eb.addr*DW2 +: DW2], eb.addr, eb.data[DW2-1:0]);
        else passed++;
      end
    end
  end

  task automatic xfer(input bit sel, input int nbits, input logic [31:0] frame, input bit hold,
                      output logic [31:0] r, output logic om);
    r = '0;
    om = 0;
    if (sel) ncs_b = 0; else ncs_a = 0;
    #100;
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = frame[i];
      #50;
      r = {r[30:0], sel ? cipo_b : cipo_a};
      if (i == nbits / 2) om = sel ? oe_b : oe_a;
      sclk = 1;
      #50;
      sclk = 0;
    end
    #50;
    if (!hold) begin
      ncs_a = 1;
      ncs_b = 1;
      #200;
    end
  endtask

  task automatic wr_a(input int a, input logic [7:0] d);
    wq_a.push_back('{a, {24'h0, d}});
    model_a[a*DW +: DW] = d;
    xfer(0, 16, {16'h0, 1'b1, 7'(a), d}, 0, rx, oe_mid);
  endtask

  task automatic test_reset;
    #22;
    total++; if (regs_a !== '0) $display("FAIL rst_regs got %h want 0", regs_a); else passed++;
    total++; if (ws_a !== 0) $display("FAIL rst_ws got %b want 0", ws_a); else passed++;
    total++; if (wa_a !== '0) $display("FAIL rst_waddr got %h want 0", wa_a); else passed++;
    total++; if (fe_a !== 0) $display("FAIL rst_ferr got %b want 0", fe_a); else passed++;
    total++; if (cipo_a !== 0) $display("FAIL rst_cipo got %b want 0", cipo_a); else passed++;
    total++; if (oe_a !== 0) $display("FAIL rst_oe got %b want 0", oe_a); else passed++;
    rst = 0;
    #100;
  endtask

  task automatic test_write;
    wr_a(2, 8'h81);
    total++; if (regs_a !== model_a) $display("FAIL write_regs got %h want %h", regs_a, model_a); else passed++;
    total++; if (ws_cnt_a !== 1) $display("FAIL write_strobes got %0d want 1", ws_cnt_a); else passed++;
    total++; if (fe_cnt_a !== 0) $display("FAIL write_ferr got %0d want 0", fe_cnt_a); else passed++;
  endtask

  task automatic test_read;
    wr_a(4, 8'hAA);
    rd_q.push_back(32'hAA);
    xfer(0, 16, 32'h0400, 0, rx, oe_mid);
    rexp = rd_q.pop_front();
    total++; if (rx[7:0] !== rexp[7:0]) $display("FAIL read_data got %h want %h", rx[7:0], rexp[7:0]); else passed++;
    total++; if (oe_mid !== 1) $display("FAIL read_oe_mid got %b want 1", oe_mid); else passed++;
    total++; if (oe_a !== 0) $display("FAIL read_oe_idle got %b want 0", oe_a); else passed++;
    total++; if (regs_a !== model_a) $display("FAIL read_regs got %h want %h", regs_a, model_a); else passed++;
    total++; if (ws_cnt_a !== 2 || fe_cnt_a !== 0)
      $display("FAIL read_counts got ws=%0d fe=%0d want ws=2 fe=0", ws_cnt_a, fe_cnt_a); else passed++;
  endtask

  task automatic test_bad_addr;
    xfer(0, 16, 32'h85FF, 0, rx, oe_mid);
    total++; if (regs_a !== model_a) $display("FAIL badaddr_regs got %h want %h", regs_a, model_a); else passed++;
    total++; if (fe_cnt_a !== 1) $display("FAIL badaddr_ferr got %0d want 1", fe_cnt_a); else passed++;
    total++; if (ws_cnt_a !== 2) $display("FAIL badaddr_ws got %0d want 2", ws_cnt_a); else passed++;
  endtask

  task automatic test_length;
    xfer(0, 12, 32'h815, 0, rx, oe_mid);
    total++; if (fe_cnt_a !== 2) $display("FAIL short_ferr got %0d want 2", fe_cnt_a); else passed++;
    xfer(0, 17, 32'h102AB, 0, rx, oe_mid);
    total++; if (fe_cnt_a !== 3) $display("FAIL long_ferr got %0d want 3", fe_cnt_a); else passed++;
    total++; if (regs_a !== model_a) $display("FAIL length_regs got %h want %h", regs_a, model_a); else passed++;
    total++; if (ws_cnt_a !== 2) $display("FAIL length_ws got %0d want 2", ws_cnt_a); else passed++;
  endtask

  task automatic test_reset_mid;
    xfer(0, 8, 32'h80, 1, rx, oe_mid);
    rst = 1;
    #30;
    total++; if (regs_a !== '0) $display("FAIL midrst_regs got %h want 0", regs_a); else passed++;
    ncs_a = 1;
    #30;
    rst = 0;
    #100;
    model_a = '0;
    wr_a(0, 8'h3C);
    total++; if (regs_a !== model_a) $display("FAIL midrst_write got %h want %h", regs_a, model_a); else passed++;
    total++; if (fe_cnt_a !== 3) $display("FAIL midrst_ferr got %0d want 3", fe_cnt_a); else passed++;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) wr_a((i == 2) ? 3 : i, 8'($urandom_range(0, 255)));
    total++; if (regs_a !== model_a) $display("FAIL b2b_regs got %h want %h", regs_a, model_a); else passed++;
    total++; if (ws_cnt_a !== 6) $display("FAIL b2b_ws got %0d want 6", ws_cnt_a); else passed++;
  endtask

  task automatic test_sweep;
    model_b = '0;
    wq_b.push_back('{15, 32'hBEEF});
    model_b[15*DW2 +: DW2] = 16'hBEEF;
    xfer(1, 21, 32'h1FBEEF, 0, rx, oe_mid);
    rd_q.push_back(32'hBEEF);
    xfer(1, 21, 32'h0F0000, 0, rx, oe_mid);
    rexp = rd_q.pop_front();
    total++; if (rx[15:0] !== rexp[15:0]) $display("FAIL sweep_read15 got %h want %h", rx[15:0], rexp[15:0]); else passed++;
    wq_b.push_back('{3, 32'h1234});
    model_b[3*DW2 +: DW2] = 16'h1234;
    xfer(1, 21, 32'h131234, 0, rx, oe_mid);
    rd_q.push_back(32'h1234);
    xfer(1, 21, 32'h030000, 0, rx, oe_mid);
    rexp = rd_q.pop_front();
    total++; if (rx[15:0] !== rexp[15:0]) $display("FAIL sweep_read3 got %h want %h", rx[15:0], rexp[15:0]); else passed++;
    total++; if (regs_b !== model_b) $display("FAIL sweep_regs got %h want %h", regs_b, model_b); else passed++;
    total++; if (ws_cnt_b !== 2 || fe_cnt_b !== 0)
      $display("FAIL sweep_counts got ws=%0d fe=%0d want ws=2 fe=0", ws_cnt_b, fe_cnt_b); else passed++;
    total++; if (regs_a !== model_a) $display("FAIL sweep_isolation got %h want %h", regs_a, model_a); else passed++;
  endtask

  initial begin
    model_a = '0;
    model_b = '0;
    test_reset;
    test_write;
    test_read;
    test_bad_addr;
    test_length;
    test_reset_mid;
    test_back_to_back;
    test_sweep;
    total++;
    if (wq_a.size() != 0 || wq_b.size() != 0)
      $display("FAIL pending_writes got a=%0d b=%0d want 0", wq_a.size(), wq_b.size());
    else passed++;
    done = 1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL timeout got running want finished");
      $fatal(1);
    end
  end
endmodule
